// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: operation codes and FSM states.
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_MULT = 3'd0,
    MD_DIV  = 3'd1,
    MD_MFHI = 3'd2,
    MD_MFLO = 3'd3,
    MD_MTHI = 3'd4,
    MD_MTLO = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV       = 2'd1,
    MULT_WAIT = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_div_step.sv
// One unsigned restoring-division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits and shift the resulting quotient bit in.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  // The shifted remainder needs one extra bit before the compare/subtract.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    q_next   = {q[WIDTH-2:0], 1'b0};
    rem_next = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, divisor}) begin
      rem_next  = diff[WIDTH-1:0];
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO controller: 1-bit/cycle restoring divider, req/ack hand-off to an external
// multiplier with timeout, HI/LO ownership and pipeline stall generation.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MULT_TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             mult_req,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  input  logic             mult_ack,
  input  logic [WIDTH-1:0] product_hi,
  input  logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             mult_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(MULT_TIMEOUT + 1);

  md_state_t        state;
  md_op_t           op_sel;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign op_sel = md_op_t'(op);
  assign busy   = (state != IDLE);
  assign stall  = busy & start;

  md_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q        (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_next   (quo_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      mult_req <= 1'b0;
      mult_a   <= '0;
      mult_b   <= '0;
      done     <= 1'b0;
      mult_err <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      cnt      <= '0;
      timer    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A flush in IDLE squashes whatever the pipeline presents this cycle.
          if (start && !flush) begin
            case (op_sel)
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              MD_DIV: begin
                if (b == '0) begin
                  hi   <= '0;
                  lo   <= '0;
                  done <= 1'b1;
                end else begin
                  quo     <= a;
                  divisor <= b;
                  rem     <= '0;
                  cnt     <= CW'(WIDTH);
                  state   <= DIV;
                end
              end
              MD_MULT: begin
                mult_a   <= a;
                mult_b   <= b;
                mult_req <= 1'b1;
                timer    <= '0;
                state    <= MULT_WAIT;
              end
              default: ;
            endcase
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              lo    <= quo_next;
              hi    <= rem_next;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        MULT_WAIT: begin
          // Ack is checked before the timeout so a result arriving on the last cycle is kept.
          if (flush) begin
            mult_req <= 1'b0;
            state    <= IDLE;
          end else if (mult_ack) begin
            hi       <= product_hi;
            lo       <= product_lo;
            mult_req <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else if (timer == TW'(MULT_TIMEOUT - 1)) begin
            mult_req <= 1'b0;
            mult_err <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
